ab_seq_gen: RTL and testbench



---
 rtl/ab_seq_gen.sv | 140 ++++++++++++++
 tb/tb_ab_seq_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ab_seq_gen.sv
// ab_seq_gen: drives the a / b / a&b-hold pattern for the downstream sequence
// detector, then checks the detector's y output against the phase being sent.
module ab_seq_gen #(
    parameter int unsigned HOLD_W      = 4,
    parameter int unsigned GAP         = 1,
    // Value match_cnt takes when a start is accepted (0 in normal use).
    parameter logic [7:0]  CNT_PRELOAD = 8'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              y_in,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        match_cnt
);

    localparam int unsigned GAP_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State, counters, checker results and Moore outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state, phase counters, y checker and next-state output decode
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero length still produces one a&b cycle.
                    hold_d  = (hold_len == '0) ? HOLD_W'(1) : hold_len;
                    err_d   = 1'b0;
                    cnt_d   = CNT_PRELOAD;
                    state_d = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                if (y_in) err_d = 1'b1;
                state_d = ST_SEND_B;
            end
            ST_SEND_B: begin
                if (y_in) err_d = 1'b1;
                hold_cnt_d = hold_q - HOLD_W'(1);
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (y_in) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
                if (hold_cnt_q == '0) begin
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = GAP_W'(GAP - 1);
                        state_d   = ST_GAP;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (y_in) err_d = 1'b1;
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        a_d    = (state_d == ST_SEND_A) || (state_d == ST_HOLD);
        b_d    = (state_d == ST_SEND_B) || (state_d == ST_HOLD);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_ab_seq_gen.sv
// tb_ab_seq_gen: three generator instances (GAP=1, GAP=0, GAP=1 with count
// preload 250) share stimulus; each has a queue-based expected-waveform model.
module tb_ab_seq_gen;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] hold_len;
    int         ymode;
    logic       yrand;
    logic       chk_en;

    logic       a_w    [NI];
    logic       b_w    [NI];
    logic       busy_w [NI];
    logic       done_w [NI];
    logic       err_w  [NI];
    logic       y_w    [NI];
    logic [7:0] cnt_w  [NI];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned GAPV = (g == 1) ? 0 : 1;
        localparam logic [7:0]  PRE  = (g == 2) ? 8'd250 : 8'd0;

        // ymode: 0 ideal detector, 1 tied 0, 2 tied 1, 3 random, 4 fires in SEND_A
        assign y_w[g] = (ymode == 0) ? (a_w[g] & b_w[g]) :
                        (ymode == 1) ? 1'b0 :
                        (ymode == 2) ? 1'b1 :
                        (ymode == 3) ? yrand : (a_w[g] & ~b_w[g]);

        ab_seq_gen #(.HOLD_W(4), .GAP(GAPV), .CNT_PRELOAD(PRE)) u_dut (
            .clk(clk), .reset(reset), .start(start), .hold_len(hold_len),
            .y_in(y_w[g]), .a(a_w[g]), .b(b_w[g]), .busy(busy_w[g]),
            .done(done_w[g]), .err(err_w[g]), .match_cnt(cnt_w[g])
        );

        // Model: queue of remaining {a,b} phases of the sequence in flight
        logic [1:0] m_q [$];
        logic       m_err, m_done;
        logic [7:0] m_cnt;

        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                m_q.delete();
                m_err = 1'b0; m_done = 1'b0; m_cnt = 8'd0;
            end else begin
                m_done = 1'b0;
                if (m_q.size() != 0) begin
                    if (m_q[0] == 2'b11) begin
                        if (y_w[g]) begin
                            if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
                        end else m_err = 1'b1;
                    end else if (y_w[g]) m_err = 1'b1;
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_done = 1'b1;
                end else if (start) begin
                    int h;
                    h = (hold_len == 4'd0) ? 1 : int'(hold_len);
                    m_q.push_back(2'b10);
                    m_q.push_back(2'b01);
                    repeat (h) m_q.push_back(2'b11);
                    repeat (GAPV) m_q.push_back(2'b00);
                    m_err = 1'b0;
                    m_cnt = PRE;
                end
            end
        end

        // Compare every output against the model each cycle
        always @(negedge clk) begin
            if (chk_en) begin
                logic ea, eb, ebusy;
                ebusy = (m_q.size() != 0);
                ea    = ebusy ? m_q[0][1] : 1'b0;
                eb    = ebusy ? m_q[0][0] : 1'b0;
                vectors++;
                if ({a_w[g], b_w[g], busy_w[g], done_w[g], err_w[g], cnt_w[g]} !==
                    {ea, eb, ebusy, m_done, m_err, m_cnt}) begin
                    miscompares++;
                    $display("FAIL model inst%0d t=%0t a,b,busy,done,err,cnt got %b%b%b%b%b %0d expected %b%b%b%b%b %0d",
                             g, $time, a_w[g], b_w[g], busy_w[g], done_w[g], err_w[g], cnt_w[g],
                             ea, eb, ebusy, m_done, m_err, m_cnt);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic slot();
        @(negedge clk);
        #1;
    endtask

    // One start pulse; counts busy cycles of instance 0 up to its done pulse
    task automatic run_seq(input logic [3:0] hl, output int busy0, output int done_seen);
        busy0 = 0;
        done_seen = 0;
        slot();
        start = 1'b1;
        hold_len = hl;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy_w[0]) busy0++;
            if (done_w[0]) begin
                done_seen = 1;
                break;
            end
            #1 start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_w[0] && !busy_w[1] && !busy_w[2]) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    initial begin
        int bc, ds, dn, seqs;
        reset = 1'b0; start = 1'b0; hold_len = 4'd0; ymode = 0; yrand = 1'b0;
        chk_en = 1'b0;
        repeat (3) slot();
        chk_en = 1'b1;
        check("rst_a", int'(a_w[0]), 0);
        check("rst_busy", int'(busy_w[0]), 0);
        check("rst_cnt", int'(cnt_w[2]), 0);
        reset = 1'b1;
        repeat (2) slot();

        // Nominal: H=3
        run_seq(4'd3, bc, ds);
        check("nom_done", ds, 1);
        check("nom_busy", bc, 6);
        check("nom_cnt", int'(cnt_w[0]), 3);
        check("nom_err", int'(err_w[0]), 0);
        check("nom_cnt_pre", int'(cnt_w[2]), 253);
        wait_idle();

        // hold_len=0 behaves as H=1
        run_seq(4'd0, bc, ds);
        check("h0_busy", bc, 4);
        check("h0_cnt", int'(cnt_w[0]), 1);
        wait_idle();

        // y stuck at 0: error is sticky into IDLE, next start clears it
        ymode = 1;
        run_seq(4'd4, bc, ds);
        check("y0_err", int'(err_w[0]), 1);
        check("y0_cnt", int'(cnt_w[0]), 0);
        slot();
        check("y0_err_idle", int'(err_w[0]), 1);
        ymode = 0;
        run_seq(4'd4, bc, ds);
        check("y0_clr_err", int'(err_w[0]), 0);
        check("y0_clr_cnt", int'(cnt_w[0]), 4);
        wait_idle();

        // y asserted during SEND_A
        ymode = 4;
        run_seq(4'd2, bc, ds);
        check("ya_err", int'(err_w[0]), 1);
        ymode = 0;
        wait_idle();

        // Reset in the third HOLD cycle of H=5
        slot();
        start = 1'b1; hold_len = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 start = 1'b0;
        end
        check("mid_ab", int'(a_w[0] & b_w[0]), 1);
        reset = 1'b0;
        #1;
        check("mid_a", int'(a_w[0]), 0);
        check("mid_busy", int'(busy_w[0]), 0);
        check("mid_cnt", int'(cnt_w[0]), 0);
        slot();
        reset = 1'b1;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dn += int'(done_w[0]) + int'(busy_w[0]);
        end
        check("mid_no_done", dn, 0);

        // Back to back with start held: GAP=0 instance repeats every 5 cycles
        slot();
        start = 1'b1; hold_len = 4'd2;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dn += int'(done_w[1]);
        end
        check("b2b_dones", dn, 4);
        #1 start = 1'b0;
        wait_idle();

        // Saturation: H=15, y forced high, 18 back-to-back sequences
        ymode = 2;
        slot();
        start = 1'b1; hold_len = 4'd15;
        seqs = 0;
        for (int i = 0; i < 18 * 19; i++) begin
            @(negedge clk);
            if (done_w[0]) begin
                seqs++;
                check("sat_cnt", int'(cnt_w[0]), 15);
                check("sat_cnt_pre", int'(cnt_w[2]), 255);
            end
        end
        check("sat_seqs", seqs, 18);
        #1 start = 1'b0;
        wait_idle();

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            slot();
            if ($urandom_range(0, 399) == 0) reset = 1'b0;
            else reset = 1'b1;
            start    = ($urandom_range(0, 3) == 0);
            hold_len = 4'($urandom_range(0, 15));
            yrand    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) ymode = $urandom_range(0, 4);
        end
        slot();
        reset = 1'b1; start = 1'b0;
        wait_idle();
        slot();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
